bsg_manycore_store_tracker: RTL and testbench
=============================================

Name: bsg_manycore_store_tracker

Overview:
- Per-tile tracker for outstanding remote stores; generalised successor to the fixed 16-bit outstanding-store counter in the tile processor wrapper.
- Gates outbound remote stores against a parametrised credit limit and implements a blocking store fence (drain-to-zero) with a handshake.
- Queues return (acknowledge) packets for locally committed remote stores in a FIFO instead of stalling when the return network is not ready.
- Sits between the core data port / packet encoder and the network, and between the remote-store decode path and the return network.

Parameters:
- x_cord_width_p, "inv": X coordinate width.
- y_cord_width_p, "inv": Y coordinate width.
- max_out_p, 16: maximum outstanding remote stores; must be >= 1.
- ret_fifo_els_p, 4: depth of the return-packet queue; must be >= 2.
- ret_packet_width_lp, 5+y_cord_width_p+x_cord_width_p: return packet width.
- cntr_width_lp, $clog2(max_out_p+1): counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- my_x_i  in  x_cord_width_p  tile X coordinate.
- my_y_i  in  y_cord_width_p  tile Y coordinate.
- req_v_i  in  1  core presents a remote store.
- req_yumi_o  out  1  store accepted by network this cycle.
- net_v_o  out  1  store valid toward network.
- net_ready_i  in  1  network ready.
- ret_v_i  in  1  incoming store acknowledge.
- ret_ready_o  out  1  constant 1.
- fence_v_i  in  1  fence request; held until yumi.
- fence_yumi_o  out  1  fence complete.
- commit_v_i  in  1  incoming remote store committed to local memory.
- commit_from_x_i  in  x_cord_width_p  sender X.
- commit_from_y_i  in  y_cord_width_p  sender Y.
- commit_ready_o  out  1  return queue can absorb a commit.
- ret_v_o  out  1  return packet valid.
- ret_data_o  out  ret_packet_width_lp  {5'b0, from_y, from_x}.
- ret_ready_i  in  1  return network ready.
- cntr_o  out  cntr_width_lp  current outstanding count.
- full_o  out  1  cntr_o == max_out_p.
- underflow_o  out  1  sticky error flag.

Behaviour:
- Reset (reset_i low, asynchronous): cntr=0, fence state IDLE, underflow_o=0, FIFO empty. Resulting outputs: net_v_o=0, fence_yumi_o=0, ret_v_o=0, full_o=0, commit_ready_o=1.
- Store gating:
  - net_v_o = req_v_i & ~full_o & ~fence_v_i & (state==IDLE).
  - fire = net_v_o & net_ready_i; req_yumi_o = fire.
- Counter update at each clock edge:
  - fire & ~ret_v_i: +1.
  - ~fire & ret_v_i & cntr>0: -1.
  - fire & ret_v_i: unchanged, including when cntr==0 and when cntr==max_out_p.
  - ~fire & ret_v_i & cntr==0: cntr stays 0 and underflow_o sets. It clears only on reset.
- The counter never exceeds max_out_p; full_o blocks fire at the limit.
- Fence FSM, states IDLE / DRAIN / ACK:
  - IDLE: if fence_v_i & cntr==0, go to ACK. If fence_v_i & cntr!=0, go to DRAIN.
  - DRAIN: when cntr==0 (a decrement to 0 is seen the cycle after), go to ACK.
  - ACK: fence_yumi_o=1 for exactly one cycle, then IDLE.
  - Minimum fence latency is 1 cycle (fence_v_i at edge N, yumi during cycle N+1).
  - Stores are blocked from the cycle fence_v_i rises until the cycle after ACK.
  - Dropping fence_v_i before yumi is illegal; an assertion flags it.
- Return queue:
  - Push = commit_v_i & commit_ready_o & ({commit_from_y_i,commit_from_x_i} != {my_y_i,my_x_i}).
  - Self-addressed commits produce no packet and are always ready.
  - commit_ready_o = FIFO not full. The upstream decoder must not commit when it is low.
  - Pop = ret_v_o & ret_ready_i. Order is FIFO.
  - Simultaneous push and pop when full: no push (ready low). When empty: no bypass, so the packet appears one cycle after push.

Decomposition:
- Shared package bsg_manycore_pkg:
  - return-packet struct {5-bit op/reserved, y_cord, x_cord};
  - fence state enum;
  - return-packet width function.
- Sub-module: bsg_fifo_1r1w_small (width ret_packet_width_lp, els ret_fifo_els_p) for the return queue.
- Counter and FSM stay in the top module.

Test Plan:
- Limit: max_out_p=4, req_v_i=1, net_ready_i=1, no returns. Expect 4 fires, cntr_o=4, full_o=1, net_v_o=0. One ret_v_i then gives cntr_o=3, and the next cycle fires again.
- Simultaneous events: cntr=2, fire & ret_v_i in the same cycle keeps cntr_o=2. At cntr=0, fire & ret_v_i keeps 0 with no underflow. ret_v_i alone at 0 gives underflow_o=1, and it stays 1.
- Fence drain: cntr=3, fence_v_i=1, req_v_i=1. Expect net_v_o=0 throughout. Return 3 acks on separate cycles; fence_yumi_o is high exactly the cycle after cntr reaches 0, and stores resume the cycle after that.
- Fence at zero: cntr=0, fence_v_i at edge N. Expect fence_yumi_o during N+1 only.
- Return queue: ret_fifo_els_p=4, ret_ready_i=0. Send 5 commits from (x=1,y=2) to tile (0,0). Expect commit_ready_o=0 after 4 pushes. A self-addressed commit (from 0,0) is ready with no push. Raising ret_ready_i drains packets {5'b0,2,1} in order.
- Async reset mid-fence: in DRAIN with cntr=2 and FIFO holding 2 entries, pulse reset_i low between edges. Outputs clear immediately: fence_yumi_o=0, cntr_o=0, ret_v_o=0, underflow_o=0.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore types: return-packet op field, fence FSM states, return-packet width helper.
// No logic here; latency and backpressure are owned by the modules that import it.
package bsg_manycore_pkg;

  localparam int ret_op_width_gp = 5;

  typedef enum logic [1:0] {
    e_fence_idle  = 2'd0,
    e_fence_drain = 2'd1,
    e_fence_ack   = 2'd2
  } fence_state_e;

  function automatic int ret_packet_width(input int x_cord_width, input int y_cord_width);
    return ret_op_width_gp + y_cord_width + x_cord_width;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO, one push and one pop per cycle; data appears one cycle after push (no bypass).
// Backpressure: ready_o drops when full, so a push and a pop on a full FIFO accept only the pop.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    push, pop;

  assign ready_o = (cnt_q != cnt_width_lp'(els_p));
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    // Pointers wrap explicitly so non-power-of-two depths work.
    if (push) wptr_d = (wptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wptr_q + ptr_width_lp'(1);
    if (pop)  rptr_d = (rptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rptr_q + ptr_width_lp'(1);
    if (push && !pop)      cnt_d = cnt_q + cnt_width_lp'(1);
    else if (!push && pop) cnt_d = cnt_q - cnt_width_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_store_tracker.sv
// Outstanding remote-store tracker: credit-gated store issue, drain-to-zero fence, queued store acknowledges.
// Fence yumi at least one cycle after request; stores stall at the credit limit or during a fence; commits stall when the return queue is full.
module bsg_manycore_store_tracker
  import bsg_manycore_pkg::*;
#(
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int max_out_p       = 16,
  parameter int ret_fifo_els_p  = 4,
  localparam int ret_packet_width_lp = ret_packet_width(x_cord_width_p, y_cord_width_p),
  localparam int cntr_width_lp       = $clog2(max_out_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [x_cord_width_p-1:0]      my_x_i,
  input  logic [y_cord_width_p-1:0]      my_y_i,
  input  logic                           req_v_i,
  output logic                           req_yumi_o,
  output logic                           net_v_o,
  input  logic                           net_ready_i,
  input  logic                           ret_v_i,
  output logic                           ret_ready_o,
  input  logic                           fence_v_i,
  output logic                           fence_yumi_o,
  input  logic                           commit_v_i,
  input  logic [x_cord_width_p-1:0]      commit_from_x_i,
  input  logic [y_cord_width_p-1:0]      commit_from_y_i,
  output logic                           commit_ready_o,
  output logic                           ret_v_o,
  output logic [ret_packet_width_lp-1:0] ret_data_o,
  input  logic                           ret_ready_i,
  output logic [cntr_width_lp-1:0]       cntr_o,
  output logic                           full_o,
  output logic                           underflow_o
);

  typedef struct packed {
    logic [ret_op_width_gp-1:0] op;
    logic [y_cord_width_p-1:0]  y_cord;
    logic [x_cord_width_p-1:0]  x_cord;
  } ret_packet_s;

  fence_state_e             state_q, state_d;
  logic [cntr_width_lp-1:0] cntr_q, cntr_d;
  logic                     underflow_q, underflow_d;
  logic                     fire;
  logic                     commit_self;
  logic                     fifo_ready;
  ret_packet_s              commit_pkt;

  assign full_o      = (cntr_q == cntr_width_lp'(max_out_p));
  assign cntr_o      = cntr_q;
  assign underflow_o = underflow_q;
  assign ret_ready_o = 1'b1;

  assign net_v_o    = req_v_i & ~full_o & ~fence_v_i & (state_q == e_fence_idle);
  assign fire       = net_v_o & net_ready_i;
  assign req_yumi_o = fire;

  // A simultaneous issue and acknowledge cancel out, even at zero or at the limit.
  always_comb begin
    cntr_d      = cntr_q;
    underflow_d = underflow_q;
    if (fire && !ret_v_i) begin
      cntr_d = cntr_q + cntr_width_lp'(1);
    end else if (!fire && ret_v_i) begin
      if (cntr_q != '0) cntr_d = cntr_q - cntr_width_lp'(1);
      else              underflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    fence_yumi_o = 1'b0;
    case (state_q)
      e_fence_idle:  if (fence_v_i) state_d = (cntr_q == '0) ? e_fence_ack : e_fence_drain;
      e_fence_drain: if (cntr_q == '0) state_d = e_fence_ack;
      e_fence_ack: begin
        fence_yumi_o = 1'b1;
        state_d      = e_fence_idle;
      end
      default:       state_d = e_fence_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= e_fence_idle;
      cntr_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntr_q      <= cntr_d;
      underflow_q <= underflow_d;
    end
  end

  // Self-addressed commits need no acknowledge packet, so they never wait on the queue.
  assign commit_self    = ({commit_from_y_i, commit_from_x_i} == {my_y_i, my_x_i});
  assign commit_ready_o = fifo_ready | (commit_v_i & commit_self);

  always_comb begin
    commit_pkt        = '0;
    commit_pkt.y_cord = commit_from_y_i;
    commit_pkt.x_cord = commit_from_x_i;
  end

  bsg_fifo_1r1w_small #(
    .width_p (ret_packet_width_lp),
    .els_p   (ret_fifo_els_p)
  ) ret_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (commit_v_i & ~commit_self),
    .ready_o (fifo_ready),
    .data_i  (commit_pkt),
    .v_o     (ret_v_o),
    .data_o  (ret_data_o),
    .yumi_i  (ret_v_o & ret_ready_i)
  );

  fence_held_until_yumi: assert property (
    @(posedge clk_i) disable iff (!reset_i) (state_q != e_fence_idle) |-> fence_v_i
  );

endmodule

// File: tb/tb_bsg_manycore_store_tracker.sv
// Directed scenarios plus a randomized run against a queue/integer reference model.
module tb_bsg_manycore_store_tracker;

  localparam int XW  = 4;
  localparam int YW  = 4;
  localparam int MAX = 4;
  localparam int ELS = 4;
  localparam int RW  = 5 + YW + XW;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          reset_i;
  logic [XW-1:0] my_x_i = '0;
  logic [YW-1:0] my_y_i = '0;
  logic          req_v_i, req_yumi_o, net_v_o, net_ready_i;
  logic          ret_v_i, ret_ready_o, fence_v_i, fence_yumi_o;
  logic          commit_v_i, commit_ready_o;
  logic [XW-1:0] commit_from_x_i;
  logic [YW-1:0] commit_from_y_i;
  logic          ret_v_o, ret_ready_i;
  logic [RW-1:0] ret_data_o;
  logic [CW-1:0] cntr_o;
  logic          full_o, underflow_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_manycore_store_tracker #(
    .x_cord_width_p (XW), .y_cord_width_p (YW), .max_out_p (MAX), .ret_fifo_els_p (ELS)
  ) dut (
    .clk_i (clk), .reset_i (reset_i), .my_x_i (my_x_i), .my_y_i (my_y_i),
    .req_v_i (req_v_i), .req_yumi_o (req_yumi_o), .net_v_o (net_v_o), .net_ready_i (net_ready_i),
    .ret_v_i (ret_v_i), .ret_ready_o (ret_ready_o), .fence_v_i (fence_v_i), .fence_yumi_o (fence_yumi_o),
    .commit_v_i (commit_v_i), .commit_from_x_i (commit_from_x_i), .commit_from_y_i (commit_from_y_i),
    .commit_ready_o (commit_ready_o), .ret_v_o (ret_v_o), .ret_data_o (ret_data_o), .ret_ready_i (ret_ready_i),
    .cntr_o (cntr_o), .full_o (full_o), .underflow_o (underflow_o)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_v_i = 0; net_ready_i = 0; ret_v_i = 0; fence_v_i = 0;
    commit_v_i = 0; commit_from_x_i = '0; commit_from_y_i = '0; ret_ready_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 0;
    #3;
    checks++; if (net_v_o !== 1'b0) begin errors++; $display("FAIL reset_net_v got=%b exp=0", net_v_o); end
    checks++; if (fence_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_fence_yumi got=%b exp=0", fence_yumi_o); end
    checks++; if (ret_v_o !== 1'b0) begin errors++; $display("FAIL reset_ret_v got=%b exp=0", ret_v_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_o); end
    checks++; if (commit_ready_o !== 1'b1) begin errors++; $display("FAIL reset_commit_ready got=%b exp=1", commit_ready_o); end
    checks++; if (cntr_o !== CW'(0)) begin errors++; $display("FAIL reset_cntr got=%0d exp=0", cntr_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow_o); end
    checks++; if (ret_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ret_ready got=%b exp=1", ret_ready_o); end
    @(posedge clk);
    #1 reset_i = 1;
  endtask

  task automatic test_limit();
    int fires = 0;
    do_reset();
    req_v_i = 1; net_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      #3;
      if (req_yumi_o === 1'b1) fires++;
      next_cycle();
    end
    checks++; if (fires != MAX) begin errors++; $display("FAIL limit_fires got=%0d exp=%0d", fires, MAX); end
    checks++; if (cntr_o !== CW'(MAX)) begin errors++; $display("FAIL limit_cntr got=%0d exp=%0d", cntr_o, MAX); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL limit_full got=%b exp=1", full_o); end
    checks++; if (net_v_o !== 1'b0) begin errors++; $display("FAIL limit_net_v got=%b exp=0", net_v_o); end
    ret_v_i = 1;
    next_cycle();
    ret_v_i = 0;
    #3;
    checks++; if (cntr_o !== CW'(MAX - 1)) begin errors++; $display("FAIL limit_after_ret got=%0d exp=%0d", cntr_o, MAX - 1); end
    checks++; if (req_yumi_o !== 1'b1) begin errors++; $display("FAIL limit_refire got=%b exp=1", req_yumi_o); end
    next_cycle();
    checks++; if (cntr_o !== CW'(MAX)) begin errors++; $display("FAIL limit_refill got=%0d exp=%0d", cntr_o, MAX); end
    req_v_i = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_v_i = 1; net_ready_i = 1;
    next_cycle(); next_cycle();
    ret_v_i = 1;
    next_cycle();
    checks++; if (cntr_o !== CW'(2)) begin errors++; $display("FAIL simul_at2 got=%0d exp=2", cntr_o); end
    req_v_i = 0;
    next_cycle(); next_cycle();
    req_v_i = 1;
    next_cycle();
    checks++; if (cntr_o !== CW'(0)) begin errors++; $display("FAIL simul_at0_cntr got=%0d exp=0", cntr_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL simul_at0_underflow got=%b exp=0", underflow_o); end
    req_v_i = 0;
    next_cycle();
    ret_v_i = 0;
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", underflow_o); end
    checks++; if (cntr_o !== CW'(0)) begin errors++; $display("FAIL underflow_cntr got=%0d exp=0", cntr_o); end
    next_cycle(); next_cycle();
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", underflow_o); end
  endtask

  task automatic test_fence_drain();
    int zc = -1, yc = -1, ycount = 0, bad = 0;
    logic resumed = 1'b0;
    do_reset();
    req_v_i = 1; net_ready_i = 1;
    repeat (3) next_cycle();
    checks++; if (cntr_o !== CW'(3)) begin errors++; $display("FAIL drain_setup got=%0d exp=3", cntr_o); end
    fence_v_i = 1;
    for (int c = 0; c < 10; c++) begin
      ret_v_i = (c < 3);
      #3;
      if (cntr_o == CW'(0) && zc < 0) zc = c;
      if (yc >= 0 && c == yc + 1) resumed = net_v_o;
      else if ((yc < 0 || c <= yc) && net_v_o !== 1'b0) bad++;
      if (fence_yumi_o === 1'b1) begin yc = c; ycount++; end
      next_cycle();
      if (yc == c) fence_v_i = 0;
    end
    req_v_i = 0; ret_v_i = 0; fence_v_i = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL drain_blocked got=%0d stores exp=0", bad); end
    checks++; if (ycount != 1) begin errors++; $display("FAIL drain_yumi_count got=%0d exp=1", ycount); end
    checks++; if (zc != 3) begin errors++; $display("FAIL drain_zero_cycle got=%0d exp=3", zc); end
    checks++; if (yc != zc + 1) begin errors++; $display("FAIL drain_yumi_cycle got=%0d exp=%0d", yc, zc + 1); end
    checks++; if (resumed !== 1'b1) begin errors++; $display("FAIL drain_resume got=%b exp=1", resumed); end
  endtask

  task automatic test_fence_zero();
    do_reset();
    fence_v_i = 1;
    #3;
    checks++; if (fence_yumi_o !== 1'b0) begin errors++; $display("FAIL fz_before got=%b exp=0", fence_yumi_o); end
    next_cycle();
    #3;
    checks++; if (fence_yumi_o !== 1'b1) begin errors++; $display("FAIL fz_yumi got=%b exp=1", fence_yumi_o); end
    next_cycle();
    fence_v_i = 0;
    #3;
    checks++; if (fence_yumi_o !== 1'b0) begin errors++; $display("FAIL fz_after got=%b exp=0", fence_yumi_o); end
  endtask

  task automatic test_ret_queue();
    int n = 0;
    logic [RW-1:0] exp_pkt;
    do_reset();
    ret_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      commit_v_i = 1; commit_from_x_i = XW'(i + 1); commit_from_y_i = YW'(2);
      #3;
      checks++; if (commit_ready_o !== (i < ELS)) begin errors++; $display("FAIL rq_ready_%0d got=%b exp=%b", i, commit_ready_o, (i < ELS)); end
      if (i < 2) begin
        checks++; if (ret_v_o !== (i == 1)) begin errors++; $display("FAIL rq_no_bypass_%0d got=%b exp=%b", i, ret_v_o, (i == 1)); end
      end
      next_cycle();
    end
    commit_from_x_i = '0; commit_from_y_i = '0;
    #3;
    checks++; if (commit_ready_o !== 1'b1) begin errors++; $display("FAIL rq_self_ready got=%b exp=1", commit_ready_o); end
    next_cycle();
    commit_v_i = 0; ret_ready_i = 1;
    for (int c = 0; c < 10; c++) begin
      #3;
      if (ret_v_o === 1'b1) begin
        exp_pkt = {5'b0, YW'(2), XW'(n + 1)};
        checks++; if (ret_data_o !== exp_pkt) begin errors++; $display("FAIL rq_data_%0d got=%h exp=%h", n, ret_data_o, exp_pkt); end
        n++;
      end
      next_cycle();
    end
    ret_ready_i = 0;
    checks++; if (n != ELS) begin errors++; $display("FAIL rq_drain_count got=%0d exp=%0d", n, ELS); end
  endtask

  task automatic test_reset_mid_fence();
    do_reset();
    ret_v_i = 1;
    next_cycle();
    ret_v_i = 0; req_v_i = 1; net_ready_i = 1;
    commit_v_i = 1; commit_from_x_i = XW'(3); commit_from_y_i = YW'(1);
    next_cycle(); next_cycle();
    req_v_i = 0; commit_v_i = 0; fence_v_i = 1;
    next_cycle(); next_cycle();
    #2;
    checks++; if (cntr_o !== CW'(2) || ret_v_o !== 1'b1 || underflow_o !== 1'b1) begin
      errors++; $display("FAIL rmf_setup got cntr=%0d ret_v=%b uf=%b exp cntr=2 ret_v=1 uf=1", cntr_o, ret_v_o, underflow_o);
    end
    reset_i = 0;
    #1;
    checks++; if (fence_yumi_o !== 1'b0) begin errors++; $display("FAIL rmf_yumi got=%b exp=0", fence_yumi_o); end
    checks++; if (cntr_o !== CW'(0)) begin errors++; $display("FAIL rmf_cntr got=%0d exp=0", cntr_o); end
    checks++; if (ret_v_o !== 1'b0) begin errors++; $display("FAIL rmf_ret_v got=%b exp=0", ret_v_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL rmf_underflow got=%b exp=0", underflow_o); end
    fence_v_i = 0;
    next_cycle();
    reset_i = 1;
  endtask

  task automatic test_random();
    int cnt = 0;
    logic uf = 1'b0;
    logic [RW-1:0] q[$];
    logic exp_net_v, exp_fire, self, push_ok;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      req_v_i         = ($urandom_range(0, 9) < 6);
      net_ready_i     = ($urandom_range(0, 9) < 7);
      ret_v_i         = ($urandom_range(0, 9) < 3);
      commit_v_i      = ($urandom_range(0, 9) < 5);
      commit_from_x_i = XW'($urandom_range(0, 2));
      commit_from_y_i = YW'($urandom_range(0, 2));
      ret_ready_i     = ($urandom_range(0, 9) < 4);
      self      = (commit_from_x_i == my_x_i) && (commit_from_y_i == my_y_i);
      exp_net_v = req_v_i && (cnt < MAX);
      exp_fire  = exp_net_v && net_ready_i;
      #3;
      checks++; if (net_v_o !== exp_net_v) begin errors++; $display("FAIL rnd_net_v cyc=%0d got=%b exp=%b", i, net_v_o, exp_net_v); end
      checks++; if (req_yumi_o !== exp_fire) begin errors++; $display("FAIL rnd_yumi cyc=%0d got=%b exp=%b", i, req_yumi_o, exp_fire); end
      checks++; if (cntr_o !== CW'(cnt)) begin errors++; $display("FAIL rnd_cntr cyc=%0d got=%0d exp=%0d", i, cntr_o, cnt); end
      checks++; if (full_o !== (cnt == MAX)) begin errors++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", i, full_o, (cnt == MAX)); end
      checks++; if (underflow_o !== uf) begin errors++; $display("FAIL rnd_underflow cyc=%0d got=%b exp=%b", i, underflow_o, uf); end
      checks++; if (ret_v_o !== (q.size() > 0)) begin errors++; $display("FAIL rnd_ret_v cyc=%0d got=%b exp=%b", i, ret_v_o, (q.size() > 0)); end
      if (q.size() > 0) begin
        checks++; if (ret_data_o !== q[0]) begin errors++; $display("FAIL rnd_ret_data cyc=%0d got=%h exp=%h", i, ret_data_o, q[0]); end
      end
      checks++; if (commit_ready_o !== ((q.size() < ELS) || (commit_v_i && self))) begin
        errors++; $display("FAIL rnd_commit_ready cyc=%0d got=%b exp=%b", i, commit_ready_o, ((q.size() < ELS) || (commit_v_i && self)));
      end
      if (exp_fire && !ret_v_i) cnt++;
      else if (!exp_fire && ret_v_i) begin
        if (cnt > 0) cnt--;
        else uf = 1'b1;
      end
      push_ok = commit_v_i && !self && (q.size() < ELS);
      if (q.size() > 0 && ret_ready_i) void'(q.pop_front());
      if (push_ok) q.push_back({5'b0, commit_from_y_i, commit_from_x_i});
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_limit();
    test_simultaneous();
    test_fence_drain();
    test_fence_zero();
    test_ret_queue();
    test_reset_mid_fence();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
